// File: rtl/pb_enc_pkg.sv
// Shared types and helpers for the protobuf varint field encoder.
// The PB_ZIGZAG_EN macro adds sint32/sint64 to the accepted type set.
package pb_enc_pkg;

  localparam int MAX_REC_BYTES    = 15;
  localparam int MAX_VARINT_BYTES = 10;

  typedef enum logic [4:0] {
    PB_INT64  = 5'd3,
    PB_UINT64 = 5'd4,
    PB_INT32  = 5'd5,
    PB_BOOL   = 5'd8,
    PB_UINT32 = 5'd13,
    PB_ENUM   = 5'd14,
    PB_SINT32 = 5'd17,
    PB_SINT64 = 5'd18
  } pb_type_e;

  typedef struct packed {
    logic [8*MAX_REC_BYTES-1:0] data;
    logic [3:0]                 len;
  } pb_rec_t;

  function automatic logic is_varint_type(input logic [4:0] code);
    case (code)
      PB_INT64, PB_UINT64, PB_INT32, PB_BOOL, PB_UINT32, PB_ENUM: return 1'b1;
`ifdef PB_ZIGZAG_EN
      PB_SINT32, PB_SINT64: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pb_varint_field_fifo_if.sv
// Field-in / record-out handshake bundle for pb_varint_field_fifo.
interface pb_varint_field_fifo_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic         in_valid;
  logic         in_ready;
  logic [28:0]  field_id;
  logic [4:0]   field_type;
  logic [63:0]  value;
  logic         out_valid;
  logic         out_ready;
  logic [119:0] out_data;
  logic [3:0]   out_len;
  logic [CNT_W-1:0] occupancy;
  logic         err;

  modport slave (
    input  in_valid, field_id, field_type, value, out_ready,
    output in_ready, out_valid, out_data, out_len, occupancy, err
  );

  modport master (
    output in_valid, field_id, field_type, value, out_ready,
    input  in_ready, out_valid, out_data, out_len, occupancy, err
  );
endinterface

// File: rtl/pb_varint_enc.sv
// Combinational LEB128-style varint encoder: 7-bit groups LSB first,
// continuation bit on every byte but the last; unused bytes are zero.
module pb_varint_enc #(
  parameter  int IN_W = 64,
  localparam int NB   = (IN_W + 6) / 7
) (
  input  logic [IN_W-1:0] val_i,
  output logic [8*NB-1:0] bytes_o,
  output logic [3:0]      len_o
);
  localparam int PAD_W = 7 * NB;

  logic [PAD_W-1:0] pad_s;
  logic [3:0]       len_s;

  assign pad_s = PAD_W'(val_i);
  assign len_o = len_s;

  // Length is one plus the index of the highest non-empty 7-bit group.
  always_comb begin
    len_s = 4'd1;
    for (int i = 1; i < NB; i++) begin
      len_s = ((pad_s >> (7 * i)) != '0) ? 4'(i + 1) : len_s;
    end
  end

  // Emit groups below len_s; all others stay zero.
  always_comb begin
    bytes_o = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(len_s)) begin
        bytes_o[8*i +: 8] = {(i + 1 < int'(len_s)), pad_s[7*i +: 7]};
      end else begin
        bytes_o[8*i +: 8] = 8'h00;
      end
    end
  end
endmodule

// File: rtl/pb_varint_field_fifo.sv
// Protobuf varint-field encoder: one S1 register stage feeding a DEPTH-entry
// record FIFO. Zigzag types 17/18 are accepted only when PB_ZIGZAG_EN is defined.
module pb_varint_field_fifo
  import pb_enc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  pb_varint_field_fifo_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = 8 * MAX_REC_BYTES;
  localparam int VAL_W = 8 * MAX_VARINT_BYTES;

  logic             s1_valid_q, s1_valid_d;
  logic [28:0]      s1_id_q, s1_id_d;
  logic [4:0]       s1_type_q, s1_type_d;
  logic [63:0]      s1_val_q, s1_val_d;

  pb_rec_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             s1_legal_s, push_s, pop_s, s1_done_s, accept_s, out_valid_s;
  logic [63:0]      norm_val_s;
  logic [39:0]      key_bytes_s;
  logic [3:0]       key_len_s;
  logic [VAL_W-1:0] val_bytes_s;
  logic [3:0]       val_len_s;
  pb_rec_t          rec_s;

  // An illegal field leaves S1 without needing buffer space.
  assign s1_legal_s  = is_varint_type(s1_type_q) && (s1_id_q != 29'd0);
  assign out_valid_s = (count_q != '0);
  assign pop_s       = out_valid_s && bus.out_ready;
  assign push_s      = s1_valid_q && s1_legal_s && ((count_q < CNT_W'(DEPTH)) || pop_s);
  assign s1_done_s   = push_s || (s1_valid_q && !s1_legal_s);
  assign accept_s    = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !s1_valid_q || s1_done_s;
  assign bus.err       = s1_valid_q && !s1_legal_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_valid_s ? mem_q[rd_ptr_q].data : '0;
  assign bus.out_len   = out_valid_s ? mem_q[rd_ptr_q].len : 4'd0;
  assign bus.occupancy = count_q;

  // Map the raw value to the 64-bit integer the wire format carries.
  always_comb begin
    norm_val_s = s1_val_q;
    case (s1_type_q)
      PB_INT32, PB_ENUM: norm_val_s = {{32{s1_val_q[31]}}, s1_val_q[31:0]};
      PB_UINT32:         norm_val_s = {32'd0, s1_val_q[31:0]};
      PB_BOOL:           norm_val_s = {63'd0, s1_val_q[0]};
`ifdef PB_ZIGZAG_EN
      PB_SINT32:         norm_val_s = {32'd0, (s1_val_q[31:0] << 1) ^ {32{s1_val_q[31]}}};
      PB_SINT64:         norm_val_s = (s1_val_q << 1) ^ {64{s1_val_q[63]}};
`endif
      default:           norm_val_s = s1_val_q;
    endcase
  end

  pb_varint_enc #(.IN_W(32)) u_key_enc (
    .val_i   ({s1_id_q, 3'b000}),
    .bytes_o (key_bytes_s),
    .len_o   (key_len_s)
  );

  pb_varint_enc #(.IN_W(64)) u_val_enc (
    .val_i   (norm_val_s),
    .bytes_o (val_bytes_s),
    .len_o   (val_len_s)
  );

  // Value bytes start right after the key bytes.
  always_comb begin
    rec_s.data = REC_W'(key_bytes_s) | (REC_W'(val_bytes_s) << {key_len_s, 3'b000});
    rec_s.len  = key_len_s + val_len_s;
  end

  // S1 loads on handshake, otherwise drains once its field is written or rejected.
  always_comb begin
    s1_id_d   = s1_id_q;
    s1_type_d = s1_type_q;
    s1_val_d  = s1_val_q;
    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_id_d    = bus.field_id;
      s1_type_d  = bus.field_type;
      s1_val_d   = bus.value;
    end else if (s1_done_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Circular buffer pointers and occupancy.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_type_q  <= '0;
      s1_val_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_type_q  <= s1_type_d;
      s1_val_q   <= s1_val_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Record storage; stale entries are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= rec_s;
    end
  end
endmodule

// File: tb/tb_pb_varint_field_fifo.sv
// Randomised self-checking bench for pb_varint_field_fifo with a queue-based
// reference model compared every cycle, plus directed literal expectations.
module tb_pb_varint_field_fifo;
  localparam int DEPTH = 4;

  typedef struct {
    logic [119:0] data;
    logic [3:0]   len;
  } ref_rec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pb_varint_field_fifo_if #(.DEPTH(DEPTH)) bus ();

  pb_varint_field_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference encoder: repeated divide-by-128 emission of each varint.
  function automatic ref_rec_t ref_encode(input logic [28:0] id, input logic [4:0] t, input logic [63:0] v);
    ref_rec_t    r;
    logic [63:0] n;
    logic [63:0] k;
    logic [7:0]  b;
    int          pos;
    case (t)
      5'd5, 5'd14: n = 64'($signed(v[31:0]));
      5'd13:       n = 64'(v[31:0]);
      5'd8:        n = 64'(v[0]);
      5'd17:       n = v[31] ? 64'(32'((~v[31:0]) * 32'd2 + 32'd1)) : 64'(32'(v[31:0] * 32'd2));
      5'd18:       n = v[63] ? (~v) * 64'd2 + 64'd1 : v * 64'd2;
      default:     n = v;
    endcase
    r.data = '0;
    pos = 0;
    k = 64'(id) * 64'd8;
    do begin
      b = {1'b0, k[6:0]};
      k = k / 64'd128;
      if (k != 64'd0) b[7] = 1'b1;
      r.data[8*pos +: 8] = b;
      pos++;
    end while (k != 64'd0);
    k = n;
    do begin
      b = {1'b0, k[6:0]};
      k = k / 64'd128;
      if (k != 64'd0) b[7] = 1'b1;
      r.data[8*pos +: 8] = b;
      pos++;
    end while (k != 64'd0);
    r.len = 4'(pos);
    return r;
  endfunction

  function automatic bit ref_legal(input logic [28:0] id, input logic [4:0] t);
    bit ok;
    ok = (t == 5'd3) || (t == 5'd4) || (t == 5'd5) || (t == 5'd8) || (t == 5'd13) || (t == 5'd14);
`ifdef PB_ZIGZAG_EN
    ok = ok || (t == 5'd17) || (t == 5'd18);
`endif
    return ok && (id != 29'd0);
  endfunction

  // Model state: one optional pending field and a queue of finished records.
  bit          m_on;
  bit          m_s1_v;
  logic [28:0] m_s1_id;
  logic [4:0]  m_s1_t;
  logic [63:0] m_s1_val;
  ref_rec_t    m_q[$];
  bit          exp_pop, exp_cons, exp_rdy, exp_legal;
  ref_rec_t    head;

  initial begin
    m_on = 1'b0; m_s1_v = 1'b0; exp_pop = 1'b0; exp_cons = 1'b0; exp_rdy = 1'b0; exp_legal = 1'b0;
  end

  // Compare process: expected outputs for this cycle from the model state.
  always @(negedge clk) begin
    if (m_on) begin
      exp_legal = m_s1_v && ref_legal(m_s1_id, m_s1_t);
      exp_pop   = (m_q.size() > 0) && (bus.out_ready === 1'b1);
      exp_cons  = m_s1_v && (!exp_legal || (m_q.size() < DEPTH) || exp_pop);
      exp_rdy   = !m_s1_v || exp_cons;
      chk("cyc_in_ready", 128'(bus.in_ready), 128'(exp_rdy));
      chk("cyc_err", 128'(bus.err), 128'(m_s1_v && !exp_legal));
      chk("cyc_occupancy", 128'(bus.occupancy), 128'(m_q.size()));
      chk("cyc_out_valid", 128'(bus.out_valid), 128'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        head = m_q[0];
        chk("cyc_out_data", 128'(bus.out_data), 128'(head.data));
        chk("cyc_out_len", 128'(bus.out_len), 128'(head.len));
      end else begin
        chk("cyc_out_data_idle", 128'(bus.out_data), 128'd0);
        chk("cyc_out_len_idle", 128'(bus.out_len), 128'd0);
      end
    end
  end

  // Model update at the active edge using the decisions taken above.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_on   = 1'b1;
      m_s1_v = 1'b0;
      m_q.delete();
    end else if (m_on) begin
      if (exp_pop) void'(m_q.pop_front());
      if (exp_cons && exp_legal) m_q.push_back(ref_encode(m_s1_id, m_s1_t, m_s1_val));
      if (bus.in_valid && exp_rdy) begin
        m_s1_v   = 1'b1;
        m_s1_id  = bus.field_id;
        m_s1_t   = bus.field_type;
        m_s1_val = bus.value;
      end else if (exp_cons) begin
        m_s1_v = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [28:0] id, input logic [4:0] t, input logic [63:0] v);
    bus.in_valid   = 1'b1;
    bus.field_id   = id;
    bus.field_type = t;
    bus.value      = v;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (DEPTH + 4) cyc();
    bus.out_ready = 1'b0;
  endtask

  int types_tab[10] = '{3, 4, 5, 8, 13, 14, 17, 18, 0, 7};
  int acc;
  int ready_pct;
  ref_rec_t pin;

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.field_id = '0;
    bus.field_type = '0;
    bus.value = '0;
    bus.out_ready = 1'b0;

    // Pin the model against hand-encoded records.
    pin = ref_encode(29'd1, 5'd4, 64'd150);
    chk("pin_150_data", 128'(pin.data), 128'h019608);
    chk("pin_150_len", 128'(pin.len), 128'd3);
    pin = ref_encode(29'd2, 5'd5, 64'hFFFF_FFFF);
    chk("pin_neg_data", 128'(pin.data), 128'h01FFFFFFFFFFFFFFFFFF10);
    pin = ref_encode(29'h1FFF_FFFF, 5'd8, 64'd2);
    chk("pin_bool_data", 128'(pin.data), 128'h000FFFFFFFF8);
    pin = ref_encode(29'd1, 5'd17, 64'hFFFF_FFFF);
    chk("pin_zz_data", 128'(pin.data), 128'h0108);

    repeat (2) cyc();
    reset = 1'b0;
    mid();
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data", 128'(bus.out_data), 128'd0);
    chk("rst_out_len", 128'(bus.out_len), 128'd0);
    chk("rst_occupancy", 128'(bus.occupancy), 128'd0);
    chk("rst_err", 128'(bus.err), 128'd0);

    cyc();
    send(29'd1, 5'd4, 64'd150);
    mid();
    chk("lat_not_yet", 128'(bus.out_valid), 128'd0);
    cyc();
    mid();
    chk("lat_valid", 128'(bus.out_valid), 128'd1);
    chk("t1_len", 128'(bus.out_len), 128'd3);
    chk("t1_data", 128'(bus.out_data), 128'h019608);
    cyc();
    drain();

    send(29'd2, 5'd5, 64'hFFFF_FFFF);
    cyc();
    mid();
    chk("t2_len", 128'(bus.out_len), 128'd11);
    chk("t2_data", 128'(bus.out_data), 128'h01FFFFFFFFFFFFFFFFFF10);
    cyc();
    drain();

    send(29'h1FFF_FFFF, 5'd8, 64'd2);
    cyc();
    mid();
    chk("t3_len", 128'(bus.out_len), 128'd6);
    chk("t3_data", 128'(bus.out_data), 128'h000FFFFFFFF8);
    cyc();
    drain();

    send(29'd1, 5'd17, 64'hFFFF_FFFF);
    mid();
`ifdef PB_ZIGZAG_EN
    chk("t4_err", 128'(bus.err), 128'd0);
    cyc();
    mid();
    chk("t4_len", 128'(bus.out_len), 128'd2);
    chk("t4_data", 128'(bus.out_data), 128'h0108);
`else
    chk("t4_err", 128'(bus.err), 128'd1);
    cyc();
    mid();
    chk("t4_err_gone", 128'(bus.err), 128'd0);
    chk("t4_occupancy", 128'(bus.occupancy), 128'd0);
`endif
    cyc();
    drain();

    // Stall: six fields into a blocked buffer.
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid   = 1'b1;
      bus.field_id   = 29'(i + 1);
      bus.field_type = 5'd4;
      bus.value      = 64'(i * 300);
      mid();
      if (bus.in_ready === 1'b1) acc++;
      cyc();
    end
    bus.in_valid = 1'b0;
    mid();
    chk("full_accepted", 128'(acc), 128'd5);
    chk("full_occupancy", 128'(bus.occupancy), 128'd4);
    chk("full_in_ready", 128'(bus.in_ready), 128'd0);
    cyc();
    bus.out_ready = 1'b1;
    cyc();
    mid();
    chk("full_push_pop", 128'(bus.occupancy), 128'd4);
    cyc();
    drain();

    // Reset with queued records and a held S1 field.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid   = 1'b1;
      bus.field_id   = 29'(i + 10);
      bus.field_type = 5'd13;
      bus.value      = 64'(i * 1000);
      cyc();
    end
    bus.in_valid = 1'b0;
    mid();
    chk("prerst_occupancy", 128'(bus.occupancy), 128'd3);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mid();
    chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("midrst_occupancy", 128'(bus.occupancy), 128'd0);
    chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
    cyc();

    // Random traffic with varying downstream readiness.
    ready_pct = 100;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) ready_pct = (c / 200) % 4 == 0 ? 10 : (c / 200) % 4 == 1 ? 50 : (c / 200) % 4 == 2 ? 90 : 100;
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.field_id   = ($urandom_range(0, 15) == 0) ? 29'd0 : 29'($urandom) >> $urandom_range(0, 28);
      bus.field_type = 5'(types_tab[$urandom_range(0, 9)]);
      bus.value      = {$urandom, $urandom} >> $urandom_range(0, 63);
      bus.out_ready  = ($urandom_range(0, 99) < ready_pct);
      cyc();
    end
    bus.in_valid = 1'b0;
    drain();
    mid();
    chk("end_empty", 128'(bus.occupancy), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
